vga_scanout: RTL

//  Display-side end of the CPU->VGA write interface. Captures pixel writes (vga_we/vga_addr/vga_data)

---
 rtl/vga_pkg.sv | 63 ++++++
 rtl/vga_fb_ram.sv | 32 +++
 rtl/vga_scanout.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared timing, frame-buffer geometry and colour types for the VGA scan-out path.
// The VGA_TEST_PATTERN_EN build uses bar_colour() for its colour-bar generator.
package vga_pkg;

  localparam int unsigned PIX_DIV = 2;

  localparam int unsigned H_VIS   = 640;
  localparam int unsigned H_FP    = 16;
  localparam int unsigned H_SYNC  = 96;
  localparam int unsigned H_BP    = 48;
  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_VIS   = 480;
  localparam int unsigned V_FP    = 10;
  localparam int unsigned V_SYNC  = 2;
  localparam int unsigned V_BP    = 33;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam int unsigned FB_W        = 80;
  localparam int unsigned FB_H        = 60;
  localparam int unsigned FB_DEPTH    = FB_W * FB_H;
  localparam int unsigned FB_AW       = 13;
  localparam int unsigned SCALE_SHIFT = 3;

  typedef logic [23:0] rgb24_t;

  // Per-pixel control that travels alongside the colour through the pipeline.
  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
    logic fs;
  } scan_ctl_t;

  localparam scan_ctl_t CTL_IDLE = '{vis: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};

  localparam rgb24_t BAR_WHITE   = 24'hFFFFFF;
  localparam rgb24_t BAR_YELLOW  = 24'hFFFF00;
  localparam rgb24_t BAR_CYAN    = 24'h00FFFF;
  localparam rgb24_t BAR_GREEN   = 24'h00FF00;
  localparam rgb24_t BAR_MAGENTA = 24'hFF00FF;
  localparam rgb24_t BAR_RED     = 24'hFF0000;
  localparam rgb24_t BAR_BLUE    = 24'h0000FF;
  localparam rgb24_t BAR_BLACK   = 24'h000000;

  function automatic rgb24_t bar_colour(input logic [2:0] idx);
    rgb24_t c;
    c = BAR_BLACK;
    unique case (idx)
      3'd0: c = BAR_WHITE;
      3'd1: c = BAR_YELLOW;
      3'd2: c = BAR_CYAN;
      3'd3: c = BAR_GREEN;
      3'd4: c = BAR_MAGENTA;
      3'd5: c = BAR_RED;
      3'd6: c = BAR_BLUE;
      3'd7: c = BAR_BLACK;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_fb_ram.sv
// Frame buffer: one write port, one registered read port. A read and write to the same cell in
// the same cycle returns the old contents.
module vga_fb_ram
  import vga_pkg::*;
#(
  parameter int unsigned Depth = FB_DEPTH,
  parameter int unsigned AddrW = FB_AW
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  rgb24_t           wr_data_i,
  input  logic             rd_en_i,
  input  logic [AddrW-1:0] rd_addr_i,
  output rgb24_t           rd_data_o
);

  rgb24_t mem_q [Depth];
  rgb24_t rd_data_q;

  always_ff @(posedge clk) begin
    if (we_i && (wr_addr_i < AddrW'(Depth))) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: CPU-writable 80x60 frame buffer shown as 640x480@60 in 8x8 pixel blocks.
// Define VGA_TEST_PATTERN_EN to add a test_mode input that replaces the picture with colour bars.
module vga_scanout
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
`ifdef VGA_TEST_PATTERN_EN
  input  logic             test_mode,
`endif
  input  logic             vga_we,
  input  logic [FB_AW-1:0] vga_addr,
  input  logic [23:0]      vga_data,
  output logic [7:0]       vga_r,
  output logic [7:0]       vga_g,
  output logic [7:0]       vga_b,
  output logic             vga_hsync,
  output logic             vga_vsync,
  output logic             vga_de,
  output logic             frame_start
);

  localparam int unsigned DivW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [DivW-1:0] div_q;
  logic            tick;
  logic [9:0]      hcnt_q, vcnt_q;
  logic            h_last, v_last;

  assign tick   = (div_q == DivW'(PIX_DIV - 1));
  assign h_last = (hcnt_q == 10'(H_TOTAL - 1));
  assign v_last = (vcnt_q == 10'(V_TOTAL - 1));

  // S0: pixel divider and raster counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      div_q <= tick ? '0 : div_q + 1'b1;
      if (tick) begin
        hcnt_q <= h_last ? '0 : hcnt_q + 10'd1;
        if (h_last) begin
          vcnt_q <= v_last ? '0 : vcnt_q + 10'd1;
        end
      end
    end
  end

  // S1: cell address and per-pixel control
  logic [FB_AW-1:0] s1_addr_d, s1_addr_q;
  scan_ctl_t        s1_ctl_d, s1_ctl_q, s2_ctl_q;

  assign s1_addr_d = FB_AW'(vcnt_q >> SCALE_SHIFT) * FB_AW'(FB_W)
                   + FB_AW'(hcnt_q >> SCALE_SHIFT);

  always_comb begin
    s1_ctl_d     = CTL_IDLE;
    s1_ctl_d.vis = (hcnt_q < 10'(H_VIS)) && (vcnt_q < 10'(V_VIS));
    s1_ctl_d.hs  = !((hcnt_q >= 10'(H_VIS + H_FP)) && (hcnt_q < 10'(H_VIS + H_FP + H_SYNC)));
    s1_ctl_d.vs  = !((vcnt_q >= 10'(V_VIS + V_FP)) && (vcnt_q < 10'(V_VIS + V_FP + V_SYNC)));
    s1_ctl_d.fs  = (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_addr_q <= '0;
      s1_ctl_q  <= CTL_IDLE;
      s2_ctl_q  <= CTL_IDLE;
    end else if (tick) begin
      s1_addr_q <= s1_addr_d;
      s1_ctl_q  <= s1_ctl_d;
      s2_ctl_q  <= s1_ctl_q;
    end
  end

  // S2: buffer read, advancing on the same tick as the control delay line
  rgb24_t s2_rgb;

  vga_fb_ram #(
    .Depth(FB_DEPTH),
    .AddrW(FB_AW)
  ) u_fb_ram (
    .clk      (clk),
    .we_i     (vga_we),
    .wr_addr_i(vga_addr),
    .wr_data_i(vga_data),
    .rd_en_i  (tick),
    .rd_addr_i(s1_addr_q),
    .rd_data_o(s2_rgb)
  );

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] s1_bar_q, s2_bar_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_bar_q <= '0;
      s2_bar_q <= '0;
    end else if (tick) begin
      s1_bar_q <= 3'(hcnt_q / 10'(H_VIS / 8));
      s2_bar_q <= s1_bar_q;
    end
  end
`endif

  // S3: output registers
  rgb24_t s3_rgb_d, rgb_q;
  logic   hsync_q, vsync_q, de_q, fs_q;

  always_comb begin
    s3_rgb_d = s2_ctl_q.vis ? s2_rgb : '0;
`ifdef VGA_TEST_PATTERN_EN
    if (test_mode && s2_ctl_q.vis) begin
      s3_rgb_d = bar_colour(s2_bar_q);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q   <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      fs_q <= tick & s2_ctl_q.fs;
      if (tick) begin
        rgb_q   <= s3_rgb_d;
        hsync_q <= s2_ctl_q.hs;
        vsync_q <= s2_ctl_q.vs;
        de_q    <= s2_ctl_q.vis;
      end
    end
  end

  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];
  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign vga_de      = de_q;
  assign frame_start = fs_q;

endmodule
